// File: rtl/iomem_stream_fifo.sv
// iomem-bus responder bridging CPU register accesses to a TX stream FIFO
// (CPU -> sink) and an RX stream FIFO (source -> CPU), with a level interrupt.
module iomem_stream_fifo #(
   parameter logic [7:0]  BASE_BYTE = 8'h03,
   parameter int unsigned DEPTH     = 16
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        iomem_valid,
   output logic        iomem_ready,
   input  logic [3:0]  iomem_wstrb,
   input  logic [31:0] iomem_addr,
   input  logic [31:0] iomem_wdata,
   output logic [31:0] iomem_rdata,
   output logic        tx_valid,
   output logic [31:0] tx_data,
   input  logic        tx_ready,
   input  logic        rx_valid,
   input  logic [31:0] rx_data,
   output logic        rx_ready,
   output logic        irq
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned LW = AW + 1;
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_ACK  = 1'b1
   } state_e;

   state_e        state_q, state_d;
   logic [31:0]   rdata_q, rdata_d;
   logic [31:0]   tx_mem_q [DEPTH];
   logic [31:0]   rx_mem_q [DEPTH];
   logic [AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
   logic [AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
   logic [LW-1:0] tx_lvl_q, tx_lvl_d, rx_lvl_q, rx_lvl_d;
   logic          tx_ovf_q, tx_ovf_d, rx_unf_q, rx_unf_d;
   logic          tx_en_q, tx_en_d, irq_rx_en_q, irq_rx_en_d, irq_tx_en_q, irq_tx_en_d;
   logic [7:0]    thresh_q, thresh_d;
   logic          irq_q, irq_d;

   logic          sel_s, acc_s, wr_s, rd_s;
   logic [1:0]    idx_s;
   logic          tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
   logic          tx_push_s, tx_pop_s, rx_push_s, rx_pop_s;
   logic          tx_flush_s, rx_flush_s;
   logic          data_wr_s, data_rd_s, status_wr_s, ctrl_wr_s;
   logic [31:0]   status_s, ctrl_rd_s;
   logic          unused_s;

   assign sel_s  = iomem_valid && (iomem_addr[31:24] == BASE_BYTE);
   assign acc_s  = (state_q == ST_IDLE) && sel_s;
   assign wr_s   = acc_s && (iomem_wstrb != 4'h0);
   assign rd_s   = acc_s && (iomem_wstrb == 4'h0);
   assign idx_s  = iomem_addr[3:2];

   assign data_wr_s   = wr_s && (idx_s == 2'd0);
   assign data_rd_s   = rd_s && (idx_s == 2'd0);
   assign status_wr_s = wr_s && (idx_s == 2'd1);
   assign ctrl_wr_s   = wr_s && (idx_s == 2'd2);

   assign tx_full_s  = (tx_lvl_q == LVL_FULL);
   assign tx_empty_s = (tx_lvl_q == {LW{1'b0}});
   assign rx_full_s  = (rx_lvl_q == LVL_FULL);
   assign rx_empty_s = (rx_lvl_q == {LW{1'b0}});

   assign tx_flush_s = ctrl_wr_s && iomem_wstrb[0] && iomem_wdata[3];
   assign rx_flush_s = ctrl_wr_s && iomem_wstrb[0] && iomem_wdata[4];

   // Full/empty are taken from the pre-edge levels, so a push into a full TX or
   // a pop of an empty RX fails even if the other side frees/fills a slot now.
   assign tx_push_s = data_wr_s && !tx_full_s;
   assign tx_pop_s  = tx_valid && tx_ready && !tx_flush_s;
   assign rx_push_s = rx_valid && rx_ready && !rx_flush_s;
   assign rx_pop_s  = data_rd_s && !rx_empty_s;

   assign status_s  = {8'h00, 8'(rx_lvl_q), 8'(tx_lvl_q), 2'b00, rx_unf_q, tx_ovf_q,
                       rx_empty_s, rx_full_s, tx_empty_s, tx_full_s};
   assign ctrl_rd_s = {16'h0000, thresh_q, 5'b00000, irq_tx_en_q, irq_rx_en_q, tx_en_q};

   assign iomem_ready = (state_q == ST_ACK);
   assign iomem_rdata = rdata_q;
   assign tx_valid    = tx_en_q && !tx_empty_s;
   assign tx_data     = tx_empty_s ? 32'h0000_0000 : tx_mem_q[tx_rp_q];
   assign rx_ready    = !rx_full_s;
   assign irq         = irq_q;
   assign unused_s    = ^{iomem_addr[23:4], iomem_addr[1:0]};

   // Access FSM and read-data capture.
   always_comb begin
      state_d = state_q;
      rdata_d = 32'h0000_0000;
      case (state_q)
         ST_IDLE: begin
            if (sel_s) begin
               state_d = ST_ACK;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACK:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (rd_s) begin
         case (idx_s)
            2'd0:    rdata_d = rx_pop_s ? rx_mem_q[rx_rp_q] : 32'h0000_0000;
            2'd1:    rdata_d = status_s;
            2'd2:    rdata_d = ctrl_rd_s;
            default: rdata_d = 32'h0000_0000;
         endcase
      end else begin
         rdata_d = 32'h0000_0000;
      end
   end

   // FIFO pointers and levels; flush clears a FIFO and voids any same-edge transfer.
   always_comb begin
      tx_wp_d  = tx_wp_q;
      tx_rp_d  = tx_rp_q;
      tx_lvl_d = tx_lvl_q;
      rx_wp_d  = rx_wp_q;
      rx_rp_d  = rx_rp_q;
      rx_lvl_d = rx_lvl_q;
      if (tx_flush_s) begin
         tx_wp_d  = {AW{1'b0}};
         tx_rp_d  = {AW{1'b0}};
         tx_lvl_d = {LW{1'b0}};
      end else begin
         tx_wp_d  = tx_push_s ? tx_wp_q + PTR_ONE : tx_wp_q;
         tx_rp_d  = tx_pop_s ? tx_rp_q + PTR_ONE : tx_rp_q;
         tx_lvl_d = tx_lvl_q + LW'(tx_push_s) - LW'(tx_pop_s);
      end
      if (rx_flush_s) begin
         rx_wp_d  = {AW{1'b0}};
         rx_rp_d  = {AW{1'b0}};
         rx_lvl_d = {LW{1'b0}};
      end else begin
         rx_wp_d  = rx_push_s ? rx_wp_q + PTR_ONE : rx_wp_q;
         rx_rp_d  = rx_pop_s ? rx_rp_q + PTR_ONE : rx_rp_q;
         rx_lvl_d = rx_lvl_q + LW'(rx_push_s) - LW'(rx_pop_s);
      end
   end

   // Sticky error flags (set beats clear), CTRL fields and interrupt source.
   always_comb begin
      tx_ovf_d    = tx_ovf_q;
      rx_unf_d    = rx_unf_q;
      tx_en_d     = tx_en_q;
      irq_rx_en_d = irq_rx_en_q;
      irq_tx_en_d = irq_tx_en_q;
      thresh_d    = thresh_q;
      if (status_wr_s && iomem_wdata[4]) begin
         tx_ovf_d = 1'b0;
      end else begin
         tx_ovf_d = tx_ovf_q;
      end
      if (status_wr_s && iomem_wdata[5]) begin
         rx_unf_d = 1'b0;
      end else begin
         rx_unf_d = rx_unf_q;
      end
      if (data_wr_s && tx_full_s) begin
         tx_ovf_d = 1'b1;
      end else begin
         tx_ovf_d = tx_ovf_d;
      end
      if (data_rd_s && rx_empty_s) begin
         rx_unf_d = 1'b1;
      end else begin
         rx_unf_d = rx_unf_d;
      end
      if (ctrl_wr_s && iomem_wstrb[0]) begin
         {irq_tx_en_d, irq_rx_en_d, tx_en_d} = iomem_wdata[2:0];
      end else begin
         {irq_tx_en_d, irq_rx_en_d, tx_en_d} = {irq_tx_en_q, irq_rx_en_q, tx_en_q};
      end
      if (ctrl_wr_s && iomem_wstrb[1]) begin
         thresh_d = iomem_wdata[15:8];
      end else begin
         thresh_d = thresh_q;
      end
      irq_d = (irq_rx_en_q && (thresh_q != 8'h00) && (8'(rx_lvl_q) >= thresh_q)) ||
              (irq_tx_en_q && tx_empty_s);
   end

   // Control and status state registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         rdata_q     <= 32'h0000_0000;
         tx_wp_q     <= {AW{1'b0}};
         tx_rp_q     <= {AW{1'b0}};
         tx_lvl_q    <= {LW{1'b0}};
         rx_wp_q     <= {AW{1'b0}};
         rx_rp_q     <= {AW{1'b0}};
         rx_lvl_q    <= {LW{1'b0}};
         tx_ovf_q    <= 1'b0;
         rx_unf_q    <= 1'b0;
         tx_en_q     <= 1'b0;
         irq_rx_en_q <= 1'b0;
         irq_tx_en_q <= 1'b0;
         thresh_q    <= 8'h00;
         irq_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         rdata_q     <= rdata_d;
         tx_wp_q     <= tx_wp_d;
         tx_rp_q     <= tx_rp_d;
         tx_lvl_q    <= tx_lvl_d;
         rx_wp_q     <= rx_wp_d;
         rx_rp_q     <= rx_rp_d;
         rx_lvl_q    <= rx_lvl_d;
         tx_ovf_q    <= tx_ovf_d;
         rx_unf_q    <= rx_unf_d;
         tx_en_q     <= tx_en_d;
         irq_rx_en_q <= irq_rx_en_d;
         irq_tx_en_q <= irq_tx_en_d;
         thresh_q    <= thresh_d;
         irq_q       <= irq_d;
      end
   end

   // FIFO storage; contents are don't-care outside the live window.
   always_ff @(posedge clk) begin
      if (tx_push_s) begin
         tx_mem_q[tx_wp_q] <= iomem_wdata;
      end
      if (rx_push_s) begin
         rx_mem_q[rx_wp_q] <= rx_data;
      end
   end

endmodule

// File: doc/iomem_stream_fifo.md
# iomem_stream_fifo

Memory-mapped responder on the SoC `iomem` bus, the target side of the CPU's external memory interface. It bridges CPU register accesses to two word-wide streaming ports for the image pipeline:
- A TX FIFO, written by the CPU and drained by a stream sink.
- An RX FIFO, filled by a stream source and read by the CPU.

It raises a level interrupt suitable for one of the SoC's external IRQ inputs.

## Interface
- `BASE_BYTE`, 8'h03, value of `iomem_addr[31:24]` that selects this block.
- `DEPTH`, 16, entries per FIFO; power of two, 2..128.
- `clk` in 1, single clock.
- `resetn` in 1, reset, asynchronous and active-low.
- `iomem_valid` in 1, request from CPU side.
- `iomem_ready` out 1, one-cycle acknowledge.
- `iomem_wstrb` in 4, byte strobes; zero means read.
- `iomem_addr` in 32, byte address.
- `iomem_wdata` in 32, write data.
- `iomem_rdata` out 32, read data; valid while `iomem_ready`=1, 0 otherwise.
- `tx_valid` out 1, TX head valid.
- `tx_data` out 32, TX head word.
- `tx_ready` in 1, sink accepts.
- `rx_valid` in 1, source word valid.
- `rx_data` in 32, source word.
- `rx_ready` out 1, RX FIFO not full.
- `irq` out 1, registered level interrupt.

## Operation
- Select: `sel = iomem_valid && iomem_addr[31:24]==BASE_BYTE`. Register index is `iomem_addr[3:2]`. Other address bits are ignored.
- Access FSM has two states, IDLE and ACK.
  - IDLE→ACK on a clock edge with `sel`. All register side effects and the `iomem_rdata` capture happen on that edge.
  - ACK→IDLE unconditionally.
  - `iomem_ready`=1 only in ACK, so exactly one acknowledge per access.
  - `sel` is ignored while in ACK.
- Register 0, DATA:
  - Write (any nonzero `wstrb`) pushes the full `wdata` into TX. If TX is full, the word is dropped and sticky `tx_ovf` is set.
  - Read pops the RX head into `rdata`. If RX is empty, `rdata`=0 and sticky `rx_unf` is set.
- Register 1, STATUS. Read fields:
  - [0] tx_full
  - [1] tx_empty
  - [2] rx_full
  - [3] rx_empty
  - [4] tx_ovf
  - [5] rx_unf
  - [15:8] tx_level
  - [23:16] rx_level
  - All other bits read 0.
  - Writing 1 to bit 4 or bit 5 clears that sticky bit; other bits are read-only.
- Register 2, CTRL (reset 0). Read back returns bits [2:0] and [15:8].
  - [0] tx_en: `tx_valid = tx_en && !tx_empty`.
  - [1] irq_rx_en.
  - [2] irq_tx_en.
  - [3] tx_flush: write-1 pulse, self-clearing, reads 0.
  - [4] rx_flush: write-1 pulse, self-clearing, reads 0.
  - [15:8] rx_thresh.
  - Byte strobes apply: `wstrb[0]` covers bits [7:0], `wstrb[1]` covers bits [15:8].
- Register 3: reserved. Reads return 0, writes are ignored, the access is still acknowledged.
- TX stream: a word transfers on an edge with `tx_valid && tx_ready`. `tx_data` is the FIFO head and is stable while `tx_valid`=1 and not yet accepted.
- RX stream: `rx_ready = !rx_full`. A word is pushed on an edge with `rx_valid && rx_ready`.
- Interrupt: `irq` is registered from `(irq_rx_en && rx_thresh!=0 && rx_level>=rx_thresh) || (irq_tx_en && tx_empty)`.
- Levels: width is log2(DEPTH)+1, zero-extended into their STATUS fields. Pointers wrap modulo DEPTH.

## Timing
- Reset (async assert, sync to clk on release):
  - FSM=IDLE; `iomem_ready`=0; `iomem_rdata`=0.
  - Both FIFOs empty; sticky bits 0; CTRL 0.
  - `tx_valid`=0, `rx_ready`=1, `irq`=0.
  - An access in flight when reset asserts is abandoned with no acknowledge.
- Access latency: with `sel` sampled at edge k, `iomem_ready`=1 in cycle k..k+1. Back-to-back accesses complete at best every 2 cycles.
- Simultaneous events:
  - CPU push and sink pop on the same edge: full is evaluated before the pop, so a push into a full TX is dropped. Otherwise both occur and the level is unchanged.
  - CPU pop and source push on the same edge: empty is evaluated before the push, so a pop of an empty RX returns 0 and sets `rx_unf`.
  - Flush and a stream transfer on the same edge: flush wins, and the stream word is discarded (RX) or the pop is void (TX).
  - Sticky-bit set and clear on the same edge: set wins.
- `irq` lags its source condition by one cycle.

## Test plan
- Reset, then read STATUS at 0x0300_0004 → `ready` 1 cycle after `valid`; `rdata`=0x0000_000A (tx_empty and rx_empty set).
- Write 0x1111_0000+i, i=0..16, to DATA with DEPTH=16 and `tx_en`=0 → tx_level=16, tx_full=1, `tx_ovf`=1. Set `tx_en` with `tx_ready`=1 → `tx_data` sequence 0x1111_0000..0x1111_000F over 16 cycles, then `tx_valid`=0.
- Source pushes 0xA5A5_0001..0xA5A5_0003 with `rx_thresh`=3 and `irq_rx_en`=1 → `irq`=1 one cycle after the third push. Three DATA reads return the words in order and `irq` drops. A fourth read returns 0 and sets `rx_unf`. Writing STATUS=0x20 clears `rx_unf`.
- Full RX (16 words): `rx_ready`=0 and source data is held. A single CPU pop in the same cycle as an offered word → that word is accepted on the next edge.
- Write CTRL=0x18 with both FIFOs partly full → both levels 0 on the next edge, CTRL reads 0x0000_0000. Assert `resetn`=0 during an ACK → `iomem_ready` falls immediately.
- Access 0x0400_0000 → no `iomem_ready`, no state change. Access 0x0300_000C → acknowledged, `rdata`=0.
